alu_cc_unit: RTL and testbench

- Sits at the result end of the Y86 execute-stage ALU interface (add64/sub64/and64/xor64).
- Takes each ALU transaction's operands and result, and derives the ZF/SF/OF flags.
- Holds the flags in the condition-code register and evaluates the jXX/cmovXX condition for the same transaction.
- Registered, one transaction per cycle, sticky error state for illegal function codes.

---
 rtl/y86_alu_pkg.sv | 27 ++
 rtl/cc_eval.sv | 40 ++++
 rtl/alu_cc_unit.sv | 170 +++++++++++++++++
 tb/tb_alu_cc_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_alu_pkg.sv
// Shared constants for the Y86 execute-stage ALU and condition-code logic.
// Function codes, CC bit positions and the CC-unit FSM state encoding.
package y86_alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] COND_ALWAYS = 4'h0;
  localparam logic [3:0] COND_LE     = 4'h1;
  localparam logic [3:0] COND_L      = 4'h2;
  localparam logic [3:0] COND_E      = 4'h3;
  localparam logic [3:0] COND_NE     = 4'h4;
  localparam logic [3:0] COND_GE     = 4'h5;
  localparam logic [3:0] COND_G      = 4'h6;

  localparam int ZF_BIT = 2;
  localparam int SF_BIT = 1;
  localparam int OF_BIT = 0;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } cc_state_e;

endpackage

// File: rtl/cc_eval.sv
// Combinational jXX/cmovXX condition evaluator over {ZF,SF,OF}.
// Flags an undefined cond_fun so the caller can trap it.
module cc_eval
  import y86_alu_pkg::*;
#(
  parameter int FUN_W = 4
) (
  input  logic [2:0]       cc_i,
  input  logic [FUN_W-1:0] cond_fun_i,
  output logic             cnd_o,
  output logic             illegal_o
);

  logic zf;
  logic sf;
  logic of;
  logic lt;

  assign zf = cc_i[ZF_BIT];
  assign sf = cc_i[SF_BIT];
  assign of = cc_i[OF_BIT];
  assign lt = sf ^ of;

  // Decode the condition; anything past g is illegal.
  always_comb begin
    cnd_o     = 1'b0;
    illegal_o = 1'b0;
    unique case (cond_fun_i)
      FUN_W'(COND_ALWAYS): cnd_o = 1'b1;
      FUN_W'(COND_LE):     cnd_o = lt | zf;
      FUN_W'(COND_L):      cnd_o = lt;
      FUN_W'(COND_E):      cnd_o = zf;
      FUN_W'(COND_NE):     cnd_o = ~zf;
      FUN_W'(COND_GE):     cnd_o = ~lt;
      FUN_W'(COND_G):      cnd_o = ~lt & ~zf;
      default:             illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_cc_unit.sv
// Y86 condition-code register, flag generation and registered cnd.
// Optional ALU result self-check enabled by defining ALU_SELFCHECK_EN.
module alu_cc_unit
  import y86_alu_pkg::*;
#(
  parameter int W     = 64,
  parameter int FUN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [FUN_W-1:0] alu_fun,
  input  logic [W-1:0]     aluA,
  input  logic [W-1:0]     aluB,
  input  logic [W-1:0]     valE,
  input  logic             set_cc,
  input  logic [FUN_W-1:0] cond_fun,
  output logic [2:0]       cc,
  output logic             cnd,
  output logic             out_valid,
  output logic             err,
`ifdef ALU_SELFCHECK_EN
  output logic [15:0]      cc_updates,
  output logic             chk_mismatch,
  output logic [15:0]      chk_count
`else
  output logic [15:0]      cc_updates
`endif
);

  cc_state_e   state_q, state_d;
  logic [2:0]  cc_q, cc_d;
  logic        cnd_q, cnd_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic [15:0] upd_q, upd_d;

  logic        accept;
  logic        alu_ok;
  logic        cond_ill;
  logic        cnd_w;
  logic        ill;
  logic        of_w;
  logic [2:0]  flags_w;

  assign accept = in_valid && !stall && (state_q == RUN);
  assign alu_ok = (alu_fun <= FUN_W'(ALU_XOR));
  assign ill    = cond_ill || (set_cc && !alu_ok);

  // cnd sees the flags as they stood before this transaction.
  cc_eval #(
    .FUN_W(FUN_W)
  ) u_cc_eval (
    .cc_i      (cc_q),
    .cond_fun_i(cond_fun),
    .cnd_o     (cnd_w),
    .illegal_o (cond_ill)
  );

  // Signed overflow from operand and result sign bits.
  always_comb begin
    of_w = 1'b0;
    unique case (1'b1)
      (alu_fun == FUN_W'(ALU_ADD)):
        of_w = (aluA[W-1] == aluB[W-1]) &&
               (valE[W-1] != aluA[W-1]);
      (alu_fun == FUN_W'(ALU_SUB)):
        of_w = (aluA[W-1] != aluB[W-1]) &&
               (valE[W-1] != aluB[W-1]);
      default: of_w = 1'b0;
    endcase
  end

  always_comb begin
    flags_w         = '0;
    flags_w[ZF_BIT] = (valE == '0);
    flags_w[SF_BIT] = valE[W-1];
    flags_w[OF_BIT] = of_w;
  end

  // Next state: accept, trap illegal codes, freeze in ERR.
  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    cnd_d   = cnd_q;
    vld_d   = 1'b0;
    err_d   = err_q;
    upd_d   = upd_q;
    if (accept) begin
      if (ill) begin
        state_d = ERR;
        err_d   = 1'b1;
      end else begin
        vld_d = 1'b1;
        cnd_d = cnd_w;
        if (set_cc) begin
          cc_d  = flags_w;
          upd_d = upd_q + 16'd1;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cc_q    <= 3'b100;
      cnd_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      upd_q   <= '0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      cnd_q   <= cnd_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      upd_q   <= upd_d;
    end
  end

  assign cc         = cc_q;
  assign cnd        = cnd_q;
  assign out_valid  = vld_q;
  assign err        = err_q;
  assign cc_updates = upd_q;

`ifdef ALU_SELFCHECK_EN
  logic [W-1:0] ref_w;
  logic         mis_q, mis_d;
  logic [15:0]  chk_q, chk_d;

  // Reference datapath for the four ALU operations.
  always_comb begin
    ref_w = '0;
    unique case (1'b1)
      (alu_fun == FUN_W'(ALU_ADD)): ref_w = aluB + aluA;
      (alu_fun == FUN_W'(ALU_SUB)): ref_w = aluB - aluA;
      (alu_fun == FUN_W'(ALU_AND)): ref_w = aluB & aluA;
      default:                      ref_w = aluB ^ aluA;
    endcase
  end

  // Mismatch pulse and saturating mismatch counter.
  always_comb begin
    mis_d = accept && alu_ok && (ref_w != valE);
    chk_d = chk_q;
    if (mis_d && (chk_q != 16'hFFFF)) begin
      chk_d = chk_q + 16'd1;
    end
  end

  // Self-check registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
      chk_q <= '0;
    end else begin
      mis_q <= mis_d;
      chk_q <= chk_d;
    end
  end

  assign chk_mismatch = mis_q;
  assign chk_count    = chk_q;
`endif

endmodule

// File: tb/tb_alu_cc_unit.sv
// Scoreboard bench for alu_cc_unit: directed plan plus random traffic.
// Selfcheck ports exercised when ALU_SELFCHECK_EN is defined.
module tb_alu_cc_unit;
  import y86_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        set_cc = 1'b0;
  logic [3:0]  alu_fun = '0;
  logic [3:0]  cond_fun = '0;
  logic [63:0] aluA = '0;
  logic [63:0] aluB = '0;
  logic [63:0] valE = '0;
  logic [2:0]  cc;
  logic        cnd;
  logic        out_valid;
  logic        err;
  logic [15:0] cc_updates;
`ifdef ALU_SELFCHECK_EN
  logic        chk_mismatch;
  logic [15:0] chk_count;
`endif

  alu_cc_unit #(.W(64), .FUN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .stall     (stall),
    .alu_fun   (alu_fun),
    .aluA      (aluA),
    .aluB      (aluB),
    .valE      (valE),
    .set_cc    (set_cc),
    .cond_fun  (cond_fun),
    .cc        (cc),
    .cnd       (cnd),
    .out_valid (out_valid),
    .err       (err),
`ifdef ALU_SELFCHECK_EN
    .cc_updates(cc_updates),
    .chk_mismatch(chk_mismatch),
    .chk_count (chk_count)
`else
    .cc_updates(cc_updates)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        cnd;
    logic [2:0]  cc;
    logic [15:0] upd;
  } exp_t;
  exp_t sbq[$];

  logic        m_zf = 1'b1;
  logic        m_sf = 1'b0;
  logic        m_of = 1'b0;
  logic        m_err = 1'b0;
  logic [15:0] m_upd = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] alu_res(input logic [3:0] f,
      input logic [63:0] a, input logic [63:0] b);
    case (f)
      ALU_ADD: return b + a;
      ALU_SUB: return b - a;
      ALU_AND: return b & a;
      default: return b ^ a;
    endcase
  endfunction

  // Flags from a wide signed computation: overflow when the
  // 65-bit true result does not fit in 64 bits.
  function automatic logic [2:0] flags(input logic [3:0] f,
      input logic [63:0] a, input logic [63:0] b,
      input logic [63:0] v);
    logic signed [64:0] s;
    logic o;
    s = '0;
    o = 1'b0;
    if (f == ALU_ADD) begin
      s = $signed({b[63], b}) + $signed({a[63], a});
      o = s[64] ^ s[63];
    end else if (f == ALU_SUB) begin
      s = $signed({b[63], b}) - $signed({a[63], a});
      o = s[64] ^ s[63];
    end
    return {v == 64'd0, v[63], o};
  endfunction

  function automatic logic cond_val(input logic [3:0] c);
    case (c)
      COND_ALWAYS: return 1'b1;
      COND_LE:     return (m_sf ^ m_of) | m_zf;
      COND_L:      return m_sf ^ m_of;
      COND_E:      return m_zf;
      COND_NE:     return !m_zf;
      COND_GE:     return !(m_sf ^ m_of);
      COND_G:      return !(m_sf ^ m_of) && !m_zf;
      default:     return 1'b0;
    endcase
  endfunction

  task automatic issue(input logic inv, input logic stl,
      input logic [3:0] f, input logic [63:0] a,
      input logic [63:0] b, input logic [63:0] v,
      input logic sc, input logic [3:0] c);
    exp_t e;
    in_valid = inv;
    stall    = stl;
    alu_fun  = f;
    aluA     = a;
    aluB     = b;
    valE     = v;
    set_cc   = sc;
    cond_fun = c;
    if (inv && !stl && !m_err) begin
      if (c > 4'd6 || (sc && f > 4'd3)) begin
        m_err = 1'b1;
      end else begin
        e.cnd = cond_val(c);
        if (sc) begin
          {m_zf, m_sf, m_of} = flags(f, a, b, v);
          m_upd = m_upd + 16'd1;
        end
        e.cc  = {m_zf, m_sf, m_of};
        e.upd = m_upd;
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, ALU_ADD, '0, '0, '0, 1'b0, COND_ALWAYS);
  endtask

  task automatic do_reset(input logic inv);
    rst      = 1'b1;
    in_valid = inv;
    stall    = 1'b0;
    alu_fun  = ALU_ADD;
    aluA     = 64'd1;
    aluB     = 64'd1;
    valE     = 64'd2;
    set_cc   = 1'b1;
    cond_fun = COND_ALWAYS;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    {m_zf, m_sf, m_of} = 3'b100;
    m_err = 1'b0;
    m_upd = '0;
    chk("rst_cc", {61'd0, cc}, 64'h4);
    chk("rst_cnd", {63'd0, cnd}, 64'd0);
    chk("rst_vld", {63'd0, out_valid}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_upd", {48'd0, cc_updates}, 64'd0);
  endtask

  // Monitor: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      exp_t e;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse actual=1 required=0");
      end else begin
        e = sbq.pop_front();
        chk("sb_cnd", {63'd0, cnd}, {63'd0, e.cnd});
        chk("sb_cc", {61'd0, cc}, {61'd0, e.cc});
        chk("sb_upd", {48'd0, cc_updates}, {48'd0, e.upd});
      end
    end
  end

  initial begin
    logic [63:0] a, b, v;
    logic [3:0]  f, c;
    logic        sc;
    logic [2:0]  cc_hold;
    logic [15:0] upd_hold;

    @(posedge clk);
    #1;
    do_reset(1'b0);

    issue(1'b1, 1'b0, ALU_XOR, 64'd5, 64'd3, 64'd6, 1'b1, COND_E);
    chk("tp_xor_cnd", {63'd0, cnd}, 64'd1);
    chk("tp_xor_cc", {61'd0, cc}, 64'd0);
    issue(1'b1, 1'b0, ALU_XOR, '0, '0, '0, 1'b0, COND_NE);
    chk("tp_ne_cnd", {63'd0, cnd}, 64'd1);

    issue(1'b1, 1'b0, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
          64'h8000_0000_0000_0000, 1'b1, COND_ALWAYS);
    chk("tp_add_cc", {61'd0, cc}, 64'd3);
    issue(1'b1, 1'b0, ALU_ADD, '0, '0, '0, 1'b0, COND_L);
    chk("tp_l_cnd", {63'd0, cnd}, 64'd0);
    issue(1'b1, 1'b0, ALU_ADD, '0, '0, '0, 1'b0, COND_LE);
    chk("tp_le_cnd", {63'd0, cnd}, 64'd0);

    do_reset(1'b0);
    issue(1'b1, 1'b0, ALU_SUB, 64'd5, 64'd5, 64'd0, 1'b1, COND_ALWAYS);
    chk("tp_sub_cc", {61'd0, cc}, 64'h4);
    chk("tp_sub_upd", {48'd0, cc_updates}, 64'd1);
    issue(1'b1, 1'b0, ALU_SUB, '0, '0, '0, 1'b0, COND_G);
    chk("tp_g_cnd", {63'd0, cnd}, 64'd0);
    issue(1'b1, 1'b0, ALU_SUB, '0, '0, '0, 1'b0, COND_GE);
    chk("tp_ge_cnd", {63'd0, cnd}, 64'd1);

    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b1, ALU_ADD, 64'd1, 64'd2, 64'd3, 1'b1, COND_ALWAYS);
      chk("stall_vld", {63'd0, out_valid}, 64'd0);
      chk("stall_cc", {61'd0, cc}, 64'h4);
      chk("stall_upd", {48'd0, cc_updates}, 64'd1);
    end
    issue(1'b1, 1'b0, ALU_ADD, 64'd1, 64'd2, 64'd3, 1'b1, COND_ALWAYS);
    chk("unstall_vld", {63'd0, out_valid}, 64'd1);
    chk("unstall_upd", {48'd0, cc_updates}, 64'd2);
    idle();
    chk("single_pulse", {63'd0, out_valid}, 64'd0);

    for (int i = 0; i < 400; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = a;
        1: a = 64'h7FFF_FFFF_FFFF_FFFF;
        2: a = 64'h8000_0000_0000_0000;
        default: ;
      endcase
      sc = $urandom_range(0, 2) != 0;
      f  = sc ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      c  = 4'($urandom_range(0, 6));
      v  = alu_res(f, a, b);
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            f, a, b, v, sc, c);
    end
    idle();

    cc_hold  = cc;
    upd_hold = cc_updates;
    issue(1'b1, 1'b0, 4'h7, 64'd1, 64'd1, 64'd2, 1'b1, COND_ALWAYS);
    chk("ill_err", {63'd0, err}, 64'd1);
    chk("ill_vld", {63'd0, out_valid}, 64'd0);
    chk("ill_cc", {61'd0, cc}, {61'd0, cc_hold});
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, ALU_SUB, 64'd9, 64'd9, 64'd0, 1'b1, COND_E);
      chk("err_vld", {63'd0, out_valid}, 64'd0);
      chk("err_cc", {61'd0, cc}, {61'd0, cc_hold});
      chk("err_upd", {48'd0, cc_updates}, {48'd0, upd_hold});
      chk("err_sticky", {63'd0, err}, 64'd1);
    end

    do_reset(1'b1);
    issue(1'b1, 1'b0, ALU_ADD, '0, '0, '0, 1'b0, 4'h9);
    chk("illcond_err", {63'd0, err}, 64'd1);
    chk("illcond_vld", {63'd0, out_valid}, 64'd0);
    do_reset(1'b0);

    issue(1'b1, 1'b0, 4'hC, '0, '0, '0, 1'b0, COND_ALWAYS);
    chk("nocheck_fun_err", {63'd0, err}, 64'd0);
    chk("nocheck_fun_vld", {63'd0, out_valid}, 64'd1);

`ifdef ALU_SELFCHECK_EN
    issue(1'b1, 1'b0, ALU_XOR, 64'hF5, 64'd211, 64'd0, 1'b1, COND_ALWAYS);
    chk("sc_pulse", {63'd0, chk_mismatch}, 64'd1);
    chk("sc_count", {48'd0, chk_count}, 64'd1);
    issue(1'b1, 1'b0, ALU_XOR, 64'hF5, 64'd211, 64'h26, 1'b1, COND_ALWAYS);
    chk("sc_nopulse", {63'd0, chk_mismatch}, 64'd0);
    chk("sc_count2", {48'd0, chk_count}, 64'd1);
`endif

    idle();
    idle();
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
